product_bcd_converter: RTL
==========================

Name: product_bcd_converter

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly downstream of the 4x4 sequential multiplier.
- Captures its 8-bit product `p` on a start strobe and produces packed BCD digits for the seven-segment display driver.
- Start/done handshake; holds the last result until the next conversion completes.

Parameters:
- IN_W, 8, binary input width; matches the multiplier product width.
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^IN_W.
- CNT_W, 4, width of the bit counter; must satisfy 2^CNT_W > IN_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  IN_W  binary value to convert, i.e. the multiplier product `p`; sampled on the accepted start edge.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse; `bcd` is valid and updated.
- bcd  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0].

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, bcd=0, shift/scratch registers and counter cleared. All outputs are registered.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge 0 → latch `bin` into the shift register.
  - Clear the BCD scratch register; counter=IN_W; go to SHIFT.
  - busy=1 from edge 0.
- SHIFT, once per edge:
  - Each scratch digit ≥5 gets +3; then {scratch, shift} shifts left by 1; counter decrements.
  - The add-3 and the shift happen in the same cycle: adjust is combinational on the current scratch, then the adjusted value is shifted.
  - On the edge where counter reaches 0 (edge IN_W), the final shifted scratch is written to `bcd`. busy→0, done→1, state→DONE.
- DONE: done=1 for exactly one cycle. Next edge → IDLE, done→0.
- Latency: start accepted at edge 0 → done high and bcd valid after edge IN_W (8 cycles for default).
- start while in SHIFT or DONE: ignored. No queuing, no restart.
- start held high continuously: a new conversion begins on the first edge back in IDLE, giving a throughput of one result per IN_W+2 cycles.
- bcd changes only on the completing edge; intermediate scratch values are never visible on `bcd`.
- bin changes after the start edge: no effect on the running conversion.
- Reset mid-conversion: abort immediately. bcd=0, no done pulse, state=IDLE.
- Digits above the required count are always 0 for legal parameter combinations.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - On the completing edge, every leading zero digit above digit 0 is replaced by 4'hF (display-driver blank code).
  - Digit 0 is never blanked; value 0 → 12'hFF0, value 6 → 12'hFF6.
  - Same latency; blanking is applied in the final register load.
- Undefined: plain zero-padded BCD (6 → 12'h006). No extra logic.

Test Plan:
- Reset, then start with bin=8'h06 (2×3) → busy high for 8 cycles; done pulses one cycle after edge 8; bcd=12'h006 and held afterwards.
- bin=8'h0C (3×4) → bcd=12'h012. Then bin=8'hFF → bcd=12'h255; previous value held until the new done.
- bin=8'hE1 (15×15=225) → bcd=12'h225. Then bin=8'h00 → bcd=12'h000, or 12'hFF0 with LEADING_ZERO_BLANK_EN; bin=8'h06 with the macro → 12'hFF6.
- Start with bin=8'h06; pulse start with bin=8'h63 at cycle 3 → second start ignored; bcd=12'h006, exactly one done pulse.
- Start with bin=8'h63; assert rst at cycle 4 (asynchronous, between edges) → busy=0 and bcd=0 immediately; no done. Release rst, start with bin=8'h63 → bcd=12'h099.
- start held high with bin=8'h0C → done pulses every 10 cycles; each result is 12'h012.

Source files
------------

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits with 4'hF.
module product_bcd_converter #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int FW = BW + IN_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIN
  } state_t;

  state_t            state;
  logic [IN_W-1:0]   shreg;
  logic [BW-1:0]     scratch;
  logic [CNT_W-1:0]  cnt;

  logic [BW-1:0]     adj;
  logic [FW-1:0]     full;
  logic [BW-1:0]     nscr;
  logic [IN_W-1:0]   nsh;
  logic [BW-1:0]     result;

  // Add-3 on every digit >= 5, then shift scratch:shift left by one
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    full = {adj, shreg} << 1;
    nscr = full[FW-1:IN_W];
    nsh  = full[IN_W-1:0];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Replace leading zero digits above the ones digit with blank code
  always_comb begin
    logic lead;
    result = nscr;
    lead   = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && nscr[4*i +: 4] == 4'd0)
        result[4*i +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
  end
`else
  // Plain zero-padded BCD
  always_comb result = nscr;
`endif

  // Control FSM with registered busy/done/bcd outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= CNT_W'(IN_W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= nsh;
          scratch <= nscr;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            bcd   <= result;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
